// File: rtl/snake_engine.sv
// snake_engine -- grid snake game core.
//
// One move per rising slw_clk edge while running. The body is a shift
// register of {y,x} segments with segment 0 as the head. A free-running
// 2*COORD_W-bit LFSR supplies the next food position each time food is eaten.
//
// Ports:
//   slw_clk            game clock
//   reset              synchronous, active-high
//   up/down/left/right level-sensitive direction requests (priority in that order)
//   start              begin a new game from IDLE or DEAD
//   snake              MAX_LEN packed {y,x} segments, segment i at [i*2C +: 2C]
//   length             live segment count
//   write_snake        one-cycle pulse when snake/length changed on that edge
//   xfood, yfood       food position
//   score              foods eaten this game (saturating)
//   game_over          high while in DEAD
//
// Build option: define SNAKE_WRAP_EN to wrap coordinates at the grid edge;
// otherwise leaving the grid is a collision.
// LFSR polynomials are tabled for COORD_W 1..8.

module snake_engine #(
    parameter int COORD_W = 4,
    parameter int MAX_LEN = 32,
    parameter int SCORE_W = 8
) (
    input  logic                         slw_clk,
    input  logic                         reset,
    input  logic                         up,
    input  logic                         down,
    input  logic                         left,
    input  logic                         right,
    input  logic                         start,
    output logic [MAX_LEN*2*COORD_W-1:0] snake,
    output logic [$clog2(MAX_LEN+1)-1:0] length,
    output logic                         write_snake,
    output logic [COORD_W-1:0]           xfood,
    output logic [COORD_W-1:0]           yfood,
    output logic [SCORE_W-1:0]           score,
    output logic                         game_over
);
    localparam int PW = 2 * COORD_W;
    localparam int LW = $clog2(MAX_LEN + 1);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DEAD = 2'd2;

    // Encoded so that the opposite direction is dir ^ 1.
    localparam logic [1:0] D_UP    = 2'd0;
    localparam logic [1:0] D_DOWN  = 2'd1;
    localparam logic [1:0] D_LEFT  = 2'd2;
    localparam logic [1:0] D_RIGHT = 2'd3;

    // Fibonacci tap masks, bit k set for term x^(k+1).
    localparam logic [15:0] TAPS16 =
        (PW == 2)  ? 16'h0003 :
        (PW == 4)  ? 16'h000C :
        (PW == 6)  ? 16'h0030 :
        (PW == 10) ? 16'h0240 :
        (PW == 12) ? 16'h0829 :
        (PW == 14) ? 16'h2015 :
        (PW == 16) ? 16'hD008 : 16'h00B8;
    localparam logic [PW-1:0] TAPS = TAPS16[PW-1:0];

    logic [1:0]                  state;
    logic [1:0]                  dir;
    logic [PW-1:0]               lfsr;
    logic [MAX_LEN-1:0][PW-1:0]  seg;
    logic [MAX_LEN-1:0][PW-1:0]  seg_shift;
    logic [MAX_LEN-1:0][PW-1:0]  seg_init;
    logic [MAX_LEN-1:0]          hit;

    logic [COORD_W-1:0] hx, hy, nx, ny;
    logic [PW-1:0]      nxt_head;
    logic [1:0]         req_dir, new_dir;
    logic               req_vld, wall, off_grid, eat, grow, collide;
    logic [LW-1:0]      new_len, body_lim;

    assign snake = seg;
    assign hx    = seg[0][COORD_W-1:0];
    assign hy    = seg[0][PW-1:COORD_W];

    // Direction resolve and next-head computation.
    always_comb begin
        req_vld = 1'b1;
        req_dir = dir;
        if (up)         req_dir = D_UP;
        else if (down)  req_dir = D_DOWN;
        else if (left)  req_dir = D_LEFT;
        else if (right) req_dir = D_RIGHT;
        else            req_vld = 1'b0;

        new_dir = dir;
        if (req_vld && (req_dir != (dir ^ 2'b01)))
            new_dir = req_dir;

        nx   = hx;
        ny   = hy;
        wall = 1'b0;
        case (new_dir)
            D_UP:    begin ny = hy - COORD_W'(1); wall = (hy == '0); end
            D_DOWN:  begin ny = hy + COORD_W'(1); wall = (hy == '1); end
            D_LEFT:  begin nx = hx - COORD_W'(1); wall = (hx == '0); end
            default: begin nx = hx + COORD_W'(1); wall = (hx == '1); end
        endcase
`ifdef SNAKE_WRAP_EN
        off_grid = 1'b0;
`else
        off_grid = wall;
`endif
        nxt_head = {ny, nx};
        eat      = (nxt_head == {yfood, xfood});
        // At MAX_LEN an eat does not grow, so the tail still vacates.
        grow     = eat && (length != LW'(MAX_LEN));
        new_len  = grow ? length + LW'(1) : length;
        body_lim = grow ? length : length - LW'(1);
    end

    // Per-segment self-hit compare and shifted body with masking past new_len.
    assign hit[0]       = 1'b0;
    assign seg_shift[0] = nxt_head;
    for (genvar i = 1; i < MAX_LEN; i++) begin : g_seg
        assign hit[i]       = (LW'(i) < body_lim) && (seg[i] == nxt_head);
        assign seg_shift[i] = (LW'(i) < new_len) ? seg[i-1] : '0;
    end

    assign collide = off_grid | (|hit);

    always_comb begin
        seg_init    = '0;
        seg_init[0] = {COORD_W'(1), COORD_W'(3)};
        seg_init[1] = {COORD_W'(1), COORD_W'(2)};
        seg_init[2] = {COORD_W'(1), COORD_W'(1)};
    end

    always_ff @(posedge slw_clk) begin
        if (reset) begin
            state       <= IDLE;
            dir         <= D_RIGHT;
            lfsr        <= '1;
            seg         <= '0;
            length      <= '0;
            score       <= '0;
            write_snake <= 1'b0;
            game_over   <= 1'b0;
            xfood       <= COORD_W'(3);
            yfood       <= COORD_W'(3);
        end else begin
            lfsr        <= {lfsr[PW-2:0], ^(lfsr & TAPS)};
            write_snake <= 1'b0;
            case (state)
                IDLE, DEAD: begin
                    if (start) begin
                        state       <= RUN;
                        dir         <= D_RIGHT;
                        seg         <= seg_init;
                        length      <= LW'(3);
                        score       <= '0;
                        xfood       <= COORD_W'(3);
                        yfood       <= COORD_W'(3);
                        write_snake <= 1'b1;
                        game_over   <= 1'b0;
                    end
                end
                RUN: begin
                    if (collide) begin
                        state     <= DEAD;
                        game_over <= 1'b1;
                    end else begin
                        dir         <= new_dir;
                        seg         <= seg_shift;
                        length      <= new_len;
                        write_snake <= 1'b1;
                        if (eat) begin
                            if (score != '1) score <= score + SCORE_W'(1);
                            // Food takes the LFSR value present at this edge.
                            xfood <= lfsr[COORD_W-1:0];
                            yfood <= lfsr[PW-1:COORD_W];
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_snake_engine.sv
// Directed bench for snake_engine at default parameters (16x16 grid).
module tb_snake_engine;
    localparam int C  = 4;
    localparam int ML = 32;
    localparam int SW = 8;
    localparam int LW = $clog2(ML + 1);

    // {up,down,left,right,start}
    localparam logic [4:0] N = 5'b00000;
    localparam logic [4:0] U = 5'b10000;
    localparam logic [4:0] D = 5'b01000;
    localparam logic [4:0] L = 5'b00100;
    localparam logic [4:0] R = 5'b00010;
    localparam logic [4:0] S = 5'b00001;

    logic slw_clk = 1'b0;
    logic reset = 1'b1;
    logic up = 1'b0, down = 1'b0, left = 1'b0, right = 1'b0, start = 1'b0;
    logic [ML*2*C-1:0] snake;
    logic [LW-1:0]     length;
    logic              write_snake;
    logic [C-1:0]      xfood, yfood;
    logic [SW-1:0]     score;
    logic              game_over;

    int errors = 0;
    int checks = 0;
    int edges  = 0;   // LFSR advances since the last reset edge

    snake_engine #(.COORD_W(C), .MAX_LEN(ML), .SCORE_W(SW)) dut (
        .slw_clk(slw_clk), .reset(reset),
        .up(up), .down(down), .left(left), .right(right), .start(start),
        .snake(snake), .length(length), .write_snake(write_snake),
        .xfood(xfood), .yfood(yfood), .score(score), .game_over(game_over)
    );

    always #5 slw_clk = ~slw_clk;

    always @(posedge slw_clk) begin
        if (reset) edges <= 0;
        else       edges <= edges + 1;
    end

    // x^8+x^6+x^5+x^4+1, seed all-ones, stepped n times.
    function automatic logic [7:0] lfsr_at(input int n);
        logic [7:0] v;
        v = 8'hFF;
        for (int i = 0; i < n; i++) v = {v[6:0], v[7] ^ v[5] ^ v[4] ^ v[3]};
        return v;
    endfunction

    function automatic logic [7:0] seg_at(input int i);
        return snake[i*2*C +: 2*C];
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step(input logic [4:0] v);
        {up, down, left, right, start} = v;
        @(posedge slw_clk);
        #1;
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, "_snake"}, 32'(snake != '0), 32'd0);
        chk({tag, "_len"},   32'(length), 32'd0);
        chk({tag, "_ws"},    32'(write_snake), 32'd0);
        chk({tag, "_go"},    32'(game_over), 32'd0);
        chk({tag, "_score"}, 32'(score), 32'd0);
        chk({tag, "_food"},  32'({yfood, xfood}), 32'h33);
    endtask

    initial begin
        // ---------------- reset state
        reset = 1'b1;
        step(N);
        step(N);
        chk_reset_state("rst");

        // ---------------- game 1: init, eat, reversal ignored, right wall
        reset = 1'b0;
        step(S);
        chk("init_s0", 32'(seg_at(0)), 32'h13);
        chk("init_s1", 32'(seg_at(1)), 32'h12);
        chk("init_s2", 32'(seg_at(2)), 32'h11);
        chk("init_s3", 32'(seg_at(3)), 32'h00);
        chk("init_len", 32'(length), 32'd3);
        chk("init_ws", 32'(write_snake), 32'd1);
        chk("init_go", 32'(game_over), 32'd0);

        step(D);
        chk("down1_s0", 32'(seg_at(0)), 32'h23);
        step(D);
        chk("eat_s0", 32'(seg_at(0)), 32'h33);
        chk("eat_s3", 32'(seg_at(3)), 32'h12);
        chk("eat_len", 32'(length), 32'd4);
        chk("eat_score", 32'(score), 32'd1);
        chk("eat_food", 32'({yfood, xfood}), 32'(lfsr_at(edges - 1)));

        step(R);
        step(L);   // opposite of right: ignored
        chk("rev_s0", 32'(seg_at(0)), 32'h35);
        chk("rev_s1", 32'(seg_at(1)), 32'h34);
        chk("rev_go", 32'(game_over), 32'd0);

        repeat (10) step(R);
        chk("edge_s0", 32'(seg_at(0)), 32'h3F);
        step(R);
`ifdef SNAKE_WRAP_EN
        chk("wrap_s0", 32'(seg_at(0)), 32'h30);
        chk("wrap_go", 32'(game_over), 32'd0);
        chk("wrap_ws", 32'(write_snake), 32'd1);
`else
        chk("wall_go", 32'(game_over), 32'd1);
        chk("wall_ws", 32'(write_snake), 32'd0);
        chk("wall_s0", 32'(seg_at(0)), 32'h3F);
        chk("wall_len", 32'(length), 32'd4);
        chk("wall_score", 32'(score), 32'd1);
        step(R);
        chk("dead_go", 32'(game_over), 32'd1);
        chk("dead_ws", 32'(write_snake), 32'd0);
        step(S);   // restart from DEAD
        chk("restart_s0", 32'(seg_at(0)), 32'h13);
        chk("restart_len", 32'(length), 32'd3);
        chk("restart_score", 32'(score), 32'd0);
        chk("restart_go", 32'(game_over), 32'd0);
        chk("restart_food", 32'({yfood, xfood}), 32'h33);
`endif

        // ---------------- game 2: tail chase at length 4, self hit at length 5
        reset = 1'b1;
        step(N);
        reset = 1'b0;
        step(S);
        step(D);
        step(D);
        chk("g2_len4", 32'(length), 32'd4);
        step(R);   // 34
        step(U);   // 24
        step(L);   // 23 = tail, which vacates
        chk("tail1_go", 32'(game_over), 32'd0);
        chk("tail1_ws", 32'(write_snake), 32'd1);
        chk("tail1_s0", 32'(seg_at(0)), 32'h23);
        chk("tail1_s3", 32'(seg_at(3)), 32'h33);
        step(D);   // 33 = tail again
        chk("tail2_s0", 32'(seg_at(0)), 32'h33);
        chk("tail2_go", 32'(game_over), 32'd0);
        repeat (12) step(D);
        chk("col3_s0", 32'(seg_at(0)), 32'hF3);
        repeat (9) step(R);   // reaches food at (12,15)
        chk("eat2_s0", 32'(seg_at(0)), 32'hFC);
        chk("eat2_len", 32'(length), 32'd5);
        chk("eat2_score", 32'(score), 32'd2);
        chk("eat2_food", 32'({yfood, xfood}), 32'(lfsr_at(edges - 1)));
        step(U);   // EC
        step(L);   // EB
        chk("turn_s0", 32'(seg_at(0)), 32'hEB);
        chk("turn_go", 32'(game_over), 32'd0);
        step(D);   // FB = segment 3
        chk("self_go", 32'(game_over), 32'd1);
        chk("self_ws", 32'(write_snake), 32'd0);
        chk("self_s0", 32'(seg_at(0)), 32'hEB);
        chk("self_len", 32'(length), 32'd5);
        chk("self_score", 32'(score), 32'd2);

        // ---------------- game 3: start ignored in RUN, reset mid-game
        reset = 1'b1;
        step(N);
        reset = 1'b0;
        step(S);
        step(S);
        chk("run_start_s0", 32'(seg_at(0)), 32'h14);
        chk("run_start_s1", 32'(seg_at(1)), 32'h13);
        chk("run_start_len", 32'(length), 32'd3);
        reset = 1'b1;
        step(S);
        chk_reset_state("midrst");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
